// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state constants and lane helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned LANE_W = 32;

    // Access size encodings
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // FSM states
    typedef logic [2:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE    = 3'd0;
    localparam lsu_state_t ST_READ    = 3'd1;
    localparam lsu_state_t ST_CAPTURE = 3'd2;
    localparam lsu_state_t ST_WRITE   = 3'd3;
    localparam lsu_state_t ST_RESP    = 3'd4;

    // Pull the addressed byte/half out of a memory word and extend it to 32 bits
    function automatic logic [LANE_W-1:0] lane_extract(
        input logic [LANE_W-1:0] data,
        input logic [1:0]        size,
        input logic [1:0]        offset,
        input logic              is_unsigned
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [LANE_W-1:0] r;
        case (offset)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = offset[1] ? data[31:16] : data[15:0];
        case (size)
            SIZE_B:  r = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
            SIZE_H:  r = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half of a memory word with right-justified store data
    function automatic logic [LANE_W-1:0] lane_merge(
        input logic [LANE_W-1:0] word,
        input logic [LANE_W-1:0] data,
        input logic [1:0]        size,
        input logic [1:0]        offset
    );
        logic [LANE_W-1:0] r;
        r = word;
        case (size)
            SIZE_B: begin
                case (offset)
                    2'd0:    r[7:0]   = data[7:0];
                    2'd1:    r[15:8]  = data[7:0];
                    2'd2:    r[23:16] = data[7:0];
                    default: r[31:24] = data[7:0];
                endcase
            end
            SIZE_H: begin
                if (offset[1]) r[31:16] = data[15:0];
                else           r[15:0]  = data[15:0];
            end
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] load_data_c,
    output logic [31:0] merge_data_c
);

    // Both lane results computed from the word currently returned by memory
    always_comb begin
        load_data_c  = lane_extract(rd_word, size, offset, is_unsigned);
        merge_data_c = lane_merge(rd_word, wr_data, size, offset);
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit in front of a word-addressed, level-sensitive data memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] DEPTH_WORDS = ADDR_W'(DEPTH);

    lsu_state_t        state_q,      state_d;
    logic              we_q,         we_d;
    logic [1:0]        size_q,       size_d;
    logic              uns_q,        uns_d;
    logic [1:0]        off_q,        off_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic              req_ready_q,  req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q,   resp_err_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;

    logic              req_err_c;
    logic [DATA_W-1:0] load_data_c;
    logic [DATA_W-1:0] merge_data_c;

    lsu_align u_align (
        .rd_word      (mem_rdata),
        .wr_data      (wdata_q),
        .size         (size_q),
        .offset       (off_q),
        .is_unsigned  (uns_q),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    // Reject illegal size, misalignment and word index beyond the memory
    always_comb begin
        req_err_c = 1'b0;
        if (req_size == 2'b11)                                  req_err_c = 1'b1;
        if (req_size == SIZE_H && req_addr[0])                  req_err_c = 1'b1;
        if (req_size == SIZE_W && (req_addr[1:0] != 2'b00))     req_err_c = 1'b1;
        if ((req_addr >> 2) >= DEPTH_WORDS)                     req_err_c = 1'b1;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    off_d       = req_addr[1:0];
                    wdata_d     = req_wdata;
                    mem_addr_d  = req_addr >> 2;
                    mem_wdata_d = req_wdata;
                    if (req_err_c) begin
                        state_d      = ST_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_we && req_size == SIZE_W) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Memory word is sampled here; only the merged write data moves outside IDLE
                if (we_q) begin
                    state_d     = ST_WRITE;
                    mem_wdata_d = merge_data_c;
                end else begin
                    state_d      = ST_RESP;
                    resp_rdata_d = load_data_c;
                    resp_err_d   = 1'b0;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        mem_read_d   = (state_d == ST_READ) || (state_d == ST_CAPTURE);
        mem_write_d  = (state_d == ST_WRITE);
    end

    // State and output registers; reset aborts any operation and drops mem_write at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural memory and reference model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.DEPTH(64), .ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level-sensitive word memory plus the bench's own reference image
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write && mem_addr < 32'd64) mem[mem_addr[5:0]] = mem_wdata;
    end

    // Activity monitor sampled away from the active edge
    int          wr_cnt;
    int          rd_cnt;
    int          resp_cnt;
    logic [31:0] last_wdata;
    logic [31:0] last_waddr;

    always @(negedge clk) begin
        if (mem_write)  begin wr_cnt++; last_wdata = mem_wdata; last_waddr = mem_addr; end
        if (mem_read)   rd_cnt++;
        if (resp_valid) resp_cnt++;
    end

    int n_checks;
    int n_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: spec rules expressed with shifts and masks
    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || ((a >> 2) >= 32'd64);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic uns);
        logic [31:0] v;
        int sh;
        sh = 8 * int'(off);
        v  = w >> sh;
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd2) return d;
        mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        sh   = 8 * int'(off);
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    function automatic int ref_lat(input logic we, input logic [1:0] sz, input logic err);
        if (err)          return 1;
        if (!we)          return 3;
        if (sz == 2'd2)   return 2;
        return 4;
    endfunction

    // Issue one request when the unit is idle and wait (bounded) for its response
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        wr_cnt = 0; rd_cnt = 0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rdata = resp_rdata;
        err   = resp_err;
    endtask

    task automatic model_apply(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                               input logic [31:0] wdata);
        if (we && !ref_err(sz, addr))
            ref_mem[addr[7:2]] = ref_store(ref_mem[addr[7:2]], wdata, sz, addr[1:0]);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          guard;

        n_checks = 0; n_errors = 0;
        wr_cnt = 0; rd_cnt = 0; resp_cnt = 0;
        last_wdata = '0; last_waddr = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'(63 - i);
            ref_mem[i] = 32'(63 - i);
        end

        vecs[0] = '{"ld_b_u_14",  1'b0, 2'd0, 1'b1, 32'h14,  32'h0,        32'h0000_003A, 1'b0, 3, 32'h0};
        vecs[1] = '{"st_b_15",    1'b1, 2'd0, 1'b0, 32'h15,  32'hAB,       32'h0,         1'b0, 4, 32'h0000_AB3A};
        vecs[2] = '{"ld_b_s_15",  1'b0, 2'd0, 1'b0, 32'h15,  32'h0,        32'hFFFF_FFAB, 1'b0, 3, 32'h0};
        vecs[3] = '{"st_w_08",    1'b1, 2'd2, 1'b0, 32'h08,  32'hDEADBEEF, 32'h0,         1'b0, 2, 32'hDEAD_BEEF};
        vecs[4] = '{"ld_h_u_0a",  1'b0, 2'd1, 1'b1, 32'h0A,  32'h0,        32'h0000_DEAD, 1'b0, 3, 32'h0};
        vecs[5] = '{"ld_h_s_08",  1'b0, 2'd1, 1'b0, 32'h08,  32'h0,        32'hFFFF_BEEF, 1'b0, 3, 32'h0};
        vecs[6] = '{"ld_h_13",    1'b0, 2'd1, 1'b0, 32'h13,  32'h0,        32'h0,         1'b1, 1, 32'h0};
        vecs[7] = '{"ld_w_06",    1'b0, 2'd2, 1'b0, 32'h06,  32'h0,        32'h0,         1'b1, 1, 32'h0};
        vecs[8] = '{"st_b_100",   1'b1, 2'd0, 1'b0, 32'h100, 32'h77,       32'h0,         1'b1, 1, 32'h0};
        vecs[9] = '{"ld_sz3_00",  1'b0, 2'd3, 1'b0, 32'h00,  32'h0,        32'h0,         1'b1, 1, 32'h0};

        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #15;
        chk("rst_req_ready",  32'(req_ready),  32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata,      32'h0);
        chk("rst_resp_err",   32'(resp_err),   32'h0);
        chk("rst_mem_addr",   mem_addr,        32'h0);
        chk("rst_mem_read",   32'(mem_read),   32'h0);
        chk("rst_mem_write",  32'(mem_write),  32'h0);
        chk("rst_mem_wdata",  mem_wdata,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table from the reference scenarios
        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"},   32'(er), 32'(vecs[i].exp_err));
            chk({vecs[i].name, "_lat"},   32'(lat), 32'(vecs[i].exp_lat));
            chk({vecs[i].name, "_wrcnt"}, 32'(wr_cnt), (vecs[i].we && !vecs[i].exp_err) ? 32'd1 : 32'd0);
            chk({vecs[i].name, "_rdcnt"}, 32'(rd_cnt),
                (vecs[i].exp_err || (vecs[i].we && vecs[i].size == 2'd2)) ? 32'd0 : 32'd2);
            if (vecs[i].we && !vecs[i].exp_err) begin
                chk({vecs[i].name, "_wdata"}, last_wdata, vecs[i].exp_wdata);
                chk({vecs[i].name, "_waddr"}, last_waddr, vecs[i].addr >> 2);
            end
            if (vecs[i].name == "ld_b_u_14") chk("ld_b_u_14_maddr", mem_addr, 32'd5);
            model_apply(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
        end

        // Backpressure: response held while a second request waits
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
        req_addr = 32'h14; req_wdata = '0;
        @(posedge clk); #1;
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h20;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("bp_lat",   32'(lat), 32'd3);
        chk("bp_rdata", resp_rdata, ref_load(ref_mem[5], 2'd0, 2'd0, 1'b1));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(resp_valid), 32'h1);
            chk("bp_hold_rdata", resp_rdata, 32'h0000_003A);
            chk("bp_hold_maddr", mem_addr, 32'd5);
            chk("bp_hold_ready", 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_ready", 32'(req_ready), 32'h1);
        chk("bp_hs_valid", 32'(resp_valid), 32'h0);
        chk("bp_hs_maddr", mem_addr, 32'd5);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_acc_ready", 32'(req_ready), 32'h0);
        chk("bp_acc_maddr", mem_addr, 32'd8);
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("bp2_lat",   32'(lat), 32'd3);
        chk("bp2_rdata", resp_rdata, ref_mem[8]);

        // Reset during CAPTURE of a byte store
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        wr_cnt = 0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mr_capture_read", 32'(mem_read), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_req_ready",  32'(req_ready),  32'h1);
        chk("mr_resp_valid", 32'(resp_valid), 32'h0);
        chk("mr_resp_rdata", resp_rdata,      32'h0);
        chk("mr_resp_err",   32'(resp_err),   32'h0);
        chk("mr_mem_addr",   mem_addr,        32'h0);
        chk("mr_mem_read",   32'(mem_read),   32'h0);
        chk("mr_mem_write",  32'(mem_write),  32'h0);
        chk("mr_mem_wdata",  mem_wdata,       32'h0);
        @(posedge clk);
        @(negedge clk);
        resp_cnt = 0;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mr_no_resp",  32'(resp_cnt), 32'd0);
        chk("mr_no_write", 32'(wr_cnt),   32'd0);
        chk("mr_word8",    mem[8],        32'h0000_0037);

        // Randomised requests against the reference model
        for (int n = 0; n < 60; n++) begin
            logic        we;
            logic        uns;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [31:0] d;
            logic        e;
            logic [31:0] er_d;
            int          r;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 9));
            sz  = (r == 9) ? 2'd3 : 2'(r % 3);
            a   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h10F));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            d = $urandom;
            e = ref_err(sz, a);
            er_d = (e || we) ? 32'h0 : ref_load(ref_mem[a[7:2]], sz, a[1:0], uns);
            do_req(we, sz, uns, a, d, rd, er, lat);
            chk("rnd_rdata", rd, er_d);
            chk("rnd_err",   32'(er), 32'(e));
            chk("rnd_lat",   32'(lat), 32'(ref_lat(we, sz, e)));
            chk("rnd_wrcnt", 32'(wr_cnt), (we && !e) ? 32'd1 : 32'd0);
            model_apply(we, sz, a, d);
        end

        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 64; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
